// File: rtl/debouncer.sv
// debouncer: accepts a change on an already-synchronized input level only
// after it has been sampled at the new value for STABLE_CYCLES consecutive
// clocks. It outputs the clean level plus one-cycle rise/fall strobes.
//
// Optional feature (macro DEBOUNCER_REPEAT_EN): while the debounced level
// stays high, repeat_pulse fires once after REPEAT_DELAY clocks and then
// every REPEAT_PERIOD clocks. Without the macro, repeat_pulse is tied to 0.
//
// Ports:
//   clk          clock
//   resetn       synchronous, active-low reset
//   in           synchronized raw level
//   level        debounced level (registered)
//   rise         one-cycle strobe on level 0->1 (registered)
//   fall         one-cycle strobe on level 1->0 (registered)
//   repeat_pulse one-cycle auto-repeat strobe (registered, or constant 0)
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic repeat_pulse
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  // Reject parameter values that would make the counters meaningless.
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debouncer: STABLE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debouncer: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          level_d, rise_d, fall_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // Next state: cnt holds the number of consecutive samples at the new level.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state)
      LOW: begin
        if (in) begin
          state_d = RISE_PEND;
          cnt_d   = CW'(1);
        end
      end
      RISE_PEND: begin
        if (!in) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!in) begin
          state_d = FALL_PEND;
          cnt_d   = CW'(1);
        end
      end
      FALL_PEND: begin
        if (in) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          state_d = LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCER_REPEAT_EN
  logic [31:0] rcnt;
  logic        armed;
  logic        holding;

  // Counting continues only while the FSM stays in HIGH/FALL_PEND; any
  // (re)entry into HIGH or any exit to the low side restarts the delay.
  always_comb begin
    holding = (state == HIGH || state == FALL_PEND) &&
              (state_d == HIGH || state_d == FALL_PEND) &&
              !(state == FALL_PEND && state_d == HIGH);
  end

  // armed marks that the initial delay has elapsed and the period applies.
  always_ff @(posedge clk) begin
    if (!resetn || !holding) begin
      rcnt         <= '0;
      armed        <= 1'b0;
      repeat_pulse <= 1'b0;
    end else if ((!armed && rcnt == 32'(REPEAT_DELAY - 1)) ||
                 (armed && rcnt == 32'(REPEAT_PERIOD - 1))) begin
      rcnt         <= '0;
      armed        <= 1'b1;
      repeat_pulse <= 1'b1;
    end else begin
      rcnt         <= rcnt + 32'd1;
      repeat_pulse <= 1'b0;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed steps from the test plan followed by bursty
// random input, checked every cycle against a run-length reference model.
module tb_debouncer;

  localparam int STABLE = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  logic clk = 1'b0;
  logic resetn;
  logic in;
  logic level, rise, fall, repeat_pulse;

  int tests = 0;
  int fails = 0;

  // Reference model state: debounced level, length of the current run of
  // samples that disagree with it, and cycles since the level settled high.
  logic m_level = 1'b0;
  int   m_run   = 0;
  int   m_age   = 0;
  logic e_rise, e_fall, e_rep;

  debouncer #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in          (in),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic model(input logic i, input logic r);
    logic restart;
    restart = 1'b0;
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    e_rep   = 1'b0;
    if (!r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_age   = 0;
    end else begin
      if (i != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = i;
          m_run   = 0;
          restart = 1'b1;
          if (i) e_rise = 1'b1;
          else   e_fall = 1'b1;
        end
      end else begin
        if (m_run != 0) restart = 1'b1;
        m_run = 0;
      end
      if (m_level) begin
        if (restart) m_age = 0;
        else begin
          m_age++;
`ifdef DEBOUNCER_REPEAT_EN
          e_rep = (m_age >= DELAY) && (((m_age - DELAY) % PERIOD) == 0);
`endif
        end
      end
    end
  endtask

  task automatic step(input logic i, input logic r);
    @(negedge clk);
    in     = i;
    resetn = r;
    @(posedge clk);
    model(i, r);
    #1;
    tests++;
    assert (level === m_level) else begin
      fails++;
      $error("FAIL level t=%0t got=%b exp=%b", $time, level, m_level);
    end
    tests++;
    assert (rise === e_rise) else begin
      fails++;
      $error("FAIL rise t=%0t got=%b exp=%b", $time, rise, e_rise);
    end
    tests++;
    assert (fall === e_fall) else begin
      fails++;
      $error("FAIL fall t=%0t got=%b exp=%b", $time, fall, e_fall);
    end
    tests++;
    assert (repeat_pulse === e_rep) else begin
      fails++;
      $error("FAIL repeat_pulse t=%0t got=%b exp=%b", $time, repeat_pulse, e_rep);
    end
    tests++;
    assert (!(rise && fall) && !(rise && repeat_pulse)) else begin
      fails++;
      $error("FAIL strobe_overlap t=%0t rise=%b fall=%b rep=%b exp=no overlap",
             $time, rise, fall, repeat_pulse);
    end
  endtask

  task automatic hold(input logic i, input int n);
    for (int k = 0; k < n; k++) step(i, 1'b1);
  endtask

  initial begin
    int   len;
    logic v;
    resetn = 1'b0;
    in     = 1'b0;

    // Reset, then idle low.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    hold(1'b0, 20);

    // Clean press and release.
    hold(1'b1, 6);
    hold(1'b0, 6);

    // Toggling input never changes the level.
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 3);
    hold(1'b0, 3);

    // Press, 3-cycle low glitch keeps level high, then real release.
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 5);

    // Reset while high: no fall, rise again after release of reset.
    hold(1'b1, 6);
    step(1'b1, 1'b0);
    hold(1'b1, 6);

    // Held high for auto-repeat, then release.
    hold(1'b1, 30);
    hold(1'b0, 6);

    // Bursty random input with occasional resets.
    for (int n = 0; n < 200; n++) begin
      v   = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                         : int'($urandom_range(1, 5)));
      for (int k = 0; k < len; k++)
        step(v, ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
